// File: rtl/tinynpu_avmm_pkg.sv
// Shared types and constants for the NPU-side Avalon-MM burst initiator.
// Default geometry, FSM encoding, command bundle and sizing helpers.
package tinynpu_avmm_pkg;

  localparam int DEF_SDRAM_W    = 128;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_BURST_W    = 11;
  localparam int DEF_MAX_BURST  = 64;
  localparam int DEF_LEN_W      = 20;
  localparam int DEF_FIFO_DEPTH = 128;

  localparam int BEAT_BYTES = DEF_SDRAM_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_BEAT,
    DONE
  } avmm_state_e;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_LEN_W-1:0]  len;
  } avmm_cmd_t;

  // Smallest r with 2**r >= v.
  function automatic int clog2_int(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  // Byte shift that converts a beat count to a byte offset.
  function automatic int beat_shift(input int data_w);
    return clog2_int(data_w / 8);
  endfunction

endpackage

// File: rtl/avmm_rd_fifo.sv
// Show-ahead synchronous FIFO that buffers SDRAM read beats
// ahead of the consumer; reports occupancy for burst admission.
module avmm_rd_fifo
  import tinynpu_avmm_pkg::*;
#(
  parameter int W     = DEF_SDRAM_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [W-1:0]                push_data,
  input  logic                        pop,
  output logic [W-1:0]                pop_data,
  output logic [clog2_int(DEPTH):0]   count,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = clog2_int(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointer and occupancy update; simultaneous push/pop keeps count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/avmm_burst_master.sv
// Avalon-MM burst initiator: splits {dir, addr, len} commands
// into bursts, buffers read data and streams write data out.
module avmm_burst_master
  import tinynpu_avmm_pkg::*;
#(
  parameter int SDRAM_W    = DEF_SDRAM_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int BURST_W    = DEF_BURST_W,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  output logic                 done,
  output logic [SDRAM_W-1:0]   rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  input  logic [SDRAM_W-1:0]   wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [ADDR_W-1:0]    address,
  output logic [BURST_W-1:0]   burstcount,
  output logic                 read,
  output logic                 write,
  output logic [SDRAM_W-1:0]   writedata,
  output logic [SDRAM_W/8-1:0] byteenable,
  input  logic                 waitrequest,
  input  logic [SDRAM_W-1:0]   readdata,
  input  logic                 readdatavalid
);

  localparam int BEAT_B  = SDRAM_W / 8;
  localparam int BEAT_SH = beat_shift(SDRAM_W);
  localparam int CNT_W   = clog2_int(FIFO_DEPTH) + 1;

  avmm_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [BURST_W-1:0] bl_q, bl_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               read_q, read_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  avmm_cmd_t          cmd_in;
  logic [LEN_W-1:0]   rem_nxt;
  logic [BURST_W-1:0] bl_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  int                 free_beats;
  logic               room;
  logic               wr_acc;

  function automatic logic [BURST_W-1:0] clip(input logic [LEN_W-1:0] r);
    if (r < LEN_W'(MAX_BURST)) return r[BURST_W-1:0];
    return BURST_W'(MAX_BURST);
  endfunction

  assign cmd_in = '{write: cmd_write, addr: cmd_addr, len: cmd_len};

  assign rem_nxt  = rem_q - LEN_W'(bl_q);
  assign bl_nxt   = clip(rem_nxt);
  assign addr_nxt = cur_addr_q + (ADDR_W'(bl_q) << BEAT_SH);

  assign pop  = rd_valid && rd_ready;
  assign push = readdatavalid && (state_q == RD_DATA) && !fifo_full;

  // Free space counts a pop happening this cycle as already gone.
  assign free_beats = FIFO_DEPTH - int'(fifo_count) + (pop ? 1 : 0);
  assign room       = free_beats >= int'(bl_q);
  assign wr_acc     = wr_valid && !waitrequest;

  assign cmd_ready  = rst_n && (state_q == IDLE);
  assign write      = rst_n && (state_q == WR_BEAT) && wr_valid;
  assign wr_ready   = rst_n && (state_q == WR_BEAT) && !waitrequest;
  assign writedata  = wr_data;
  assign byteenable = {BEAT_B{write}};
  assign address    = cur_addr_q;
  assign burstcount = bl_q;
  assign read       = read_q;
  assign done       = done_q;
  assign rd_valid   = !fifo_empty;

  // Next-state logic: command capture, burst issue and beat counting.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    bl_d       = bl_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    read_d     = read_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dir_d      = cmd_in.write;
          cur_addr_d = cmd_in.addr & ~ADDR_W'(BEAT_B - 1);
          rem_d      = cmd_in.len;
          bl_d       = clip(cmd_in.len);
          cnt_d      = clip(cmd_in.len);
          if (cmd_in.len == '0) state_d = DONE;
          else if (cmd_in.write) state_d = WR_BEAT;
          else state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (read_q) begin
          if (!waitrequest) begin
            read_d  = 1'b0;
            state_d = RD_DATA;
          end
        end else if (room) begin
          read_d = 1'b1;
        end
      end
      RD_DATA: begin
        if (readdatavalid) begin
          cnt_d = cnt_q - BURST_W'(1);
          if (cnt_q == BURST_W'(1)) begin
            cur_addr_d = addr_nxt;
            rem_d      = rem_nxt;
            bl_d       = bl_nxt;
            cnt_d      = bl_nxt;
            state_d    = (rem_nxt == '0) ? DONE : RD_REQ;
          end
        end
      end
      WR_BEAT: begin
        if (wr_acc) begin
          cnt_d = cnt_q - BURST_W'(1);
          if (cnt_q == BURST_W'(1)) begin
            cur_addr_d = addr_nxt;
            rem_d      = rem_nxt;
            bl_d       = bl_nxt;
            cnt_d      = bl_nxt;
            state_d    = (rem_nxt == '0) ? DONE : WR_BEAT;
          end
        end
      end
      DONE: begin
        // Reads finish only once the consumer has drained every beat.
        if (dir_q || fifo_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered FSM state, burst bookkeeping and bus strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      bl_q       <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      read_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      bl_q       <= bl_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      read_q     <= read_d;
      done_q     <= done_d;
    end
  end

  avmm_rd_fifo #(
    .W     (SDRAM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (readdata),
    .pop       (pop),
    .pop_data  (rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_avmm_burst_master.sv
// Bench for avmm_burst_master: Avalon slave model, stream source/sink,
// table of command vectors plus stall, zero-length and reset sequences.
module tb_avmm_burst_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [31:0]  cmd_addr;
  logic [19:0]  cmd_len;
  logic         done;
  logic [127:0] rd_data;
  logic         rd_valid, rd_ready;
  logic [127:0] wr_data;
  logic         wr_valid, wr_ready;
  logic [31:0]  address;
  logic [10:0]  burstcount;
  logic         read, write;
  logic [127:0] writedata;
  logic [15:0]  byteenable;
  logic         waitrequest;
  logic [127:0] readdata;
  logic         readdatavalid;

  always #5 clk = ~clk;

  avmm_burst_master dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .done          (done),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .address       (address),
    .burstcount    (burstcount),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int wmode = 0;
  bit gap_en = 0;
  bit rd_ready_en = 1;

  bit          cmd_pend = 0;
  bit          cmd_w = 0;
  logic [31:0] cmd_a = '0;
  logic [19:0] cmd_l = '0;
  int          acc_cyc = -1;

  logic [127:0] src[$];
  int           src_idx = 0;

  logic [127:0] mem [logic [31:0]];
  int           rp_beats = 0, rp_lat = 0;
  logic [31:0]  rp_addr = '0;
  int           w_left = 0, w_bc = 0;
  logic [31:0]  w_addr = '0;
  logic [31:0]  b_addr[$];
  int           b_len[$];
  int           hold_cnt = 0, wait_cyc = 0;
  bit           prv_rw = 0;
  logic [31:0]  prv_a = '0;
  logic [10:0]  prv_bc = '0;

  logic [31:0] exp_rd = '0;
  int pops = 0, wbeats = 0, occ = 0, max_occ = 0;
  int done_cnt = 0, done_cyc = -1, last_pop = -1, rw_cyc = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    int          len;
    int          wm;
    int          nb;
    int          bl0;
    int          bll;
    logic [31:0] al;
  } vec_t;

  vec_t vt [6];

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_0F0F, 32'hC0DE_0000 + a};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock of the environment: drive at negedge, then observe what the
  // next posedge will capture.
  task automatic step();
    @(negedge clk);
    cmd_valid = cmd_pend;
    cmd_write = cmd_w;
    cmd_addr  = cmd_a;
    cmd_len   = cmd_l;
    case (wmode)
      1:       waitrequest = ($urandom_range(0, 9) < 4);
      2:       waitrequest = read && (hold_cnt < 3);
      default: waitrequest = 1'b0;
    endcase
    if (rp_beats > 0 && rp_lat > 0) begin
      rp_lat--;
      readdatavalid = 1'b0;
    end else if (rp_beats > 0) begin
      readdatavalid = 1'b1;
      readdata      = pat(rp_addr);
    end else begin
      readdatavalid = 1'b0;
    end
    wr_valid = (src_idx < src.size()) && !(gap_en && $urandom_range(0, 9) < 3);
    wr_data  = (src_idx < src.size()) ? src[src_idx] : '0;
    rd_ready = rd_ready_en;
    #1;
    if (cmd_valid && cmd_ready) begin
      cmd_pend = 0;
      acc_cyc  = cyc;
    end
    if (read || write) rw_cyc++;
    if (read && prv_rw) begin
      chk("rd_addr_hold", address, prv_a);
      chk("rd_bc_hold", burstcount, prv_bc);
    end
    prv_rw = read && waitrequest;
    prv_a  = address;
    prv_bc = burstcount;
    if (read && waitrequest) begin
      hold_cnt++;
      wait_cyc++;
    end
    if (read && !waitrequest) begin
      chk("one_outstanding", rp_beats, 0);
      hold_cnt = 0;
      b_addr.push_back(address);
      b_len.push_back(int'(burstcount));
      rp_beats = int'(burstcount);
      rp_addr  = address;
      rp_lat   = 2;
    end
    if (readdatavalid) begin
      rp_beats--;
      rp_addr = rp_addr + 32'd16;
      occ++;
    end
    if (rd_valid && rd_ready) begin
      chk("rd_data", rd_data, pat(exp_rd));
      exp_rd   = exp_rd + 32'd16;
      pops++;
      occ--;
      last_pop = cyc;
    end
    if (occ > max_occ) max_occ = occ;
    if (write) begin
      if (w_left == 0) begin
        w_left = int'(burstcount);
        w_bc   = int'(burstcount);
        w_addr = address;
        b_addr.push_back(address);
        b_len.push_back(int'(burstcount));
      end else begin
        chk("wr_addr_hold", address, w_addr);
        chk("wr_bc_hold", burstcount, 11'(w_bc));
      end
      if (!waitrequest) begin
        chk("byteenable", byteenable, 16'hFFFF);
        mem[w_addr + 32'((w_bc - w_left) * 16)] = writedata;
        w_left--;
        wbeats++;
      end
    end
    if (wr_valid && wr_ready) src_idx++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic start_cmd(input bit w, input logic [31:0] a, input int len);
    b_addr.delete();
    b_len.delete();
    done_cnt = 0;
    done_cyc = -1;
    acc_cyc  = -1;
    pops     = 0;
    wbeats   = 0;
    rw_cyc   = 0;
    wait_cyc = 0;
    hold_cnt = 0;
    last_pop = -1;
    max_occ  = occ;
    exp_rd   = a & 32'hFFFF_FFF0;
    cmd_w    = w;
    cmd_a    = a;
    cmd_l    = 20'(len);
    cmd_pend = 1;
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while (done_cnt == 0 && n < maxc) begin
      step();
      n++;
    end
    repeat (3) step();
    chk("done_once", done_cnt, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 32'h2000_0000,   4, 2, 1, 64'd0 + 4, 4,  32'h2000_0000};
    vt[1] = '{1, 32'h2000_0100,   3, 1, 1, 3,  3,  32'h2000_0100};
    vt[2] = '{0, 32'h1000_0000, 100, 1, 2, 64, 36, 32'h1000_0400};
    vt[3] = '{1, 32'h3000_0008,  70, 1, 2, 64, 6,  32'h3000_0400};
    vt[4] = '{0, 32'hFFFF_FFE0,  66, 1, 2, 64, 2,  32'h0000_03E0};
    vt[5] = '{1, 32'h0000_1000,  64, 0, 1, 64, 64, 32'h0000_1000};

    rst_n         = 1'b0;
    cmd_valid     = 1'b0;
    cmd_write     = 1'b0;
    cmd_addr      = '0;
    cmd_len       = '0;
    rd_ready      = 1'b1;
    wr_data       = '0;
    wr_valid      = 1'b0;
    waitrequest   = 1'b0;
    readdata      = '0;
    readdatavalid = 1'b0;

    repeat (3) step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_address", address, 0);
    chk("rst_burstcount", burstcount, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    rst_n = 1'b1;
    step();
    chk("idle_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 6; i++) begin
      wmode  = vt[i].wm;
      gap_en = vt[i].wr;
      src.delete();
      src_idx = 0;
      if (vt[i].wr) begin
        for (int j = 0; j < vt[i].len; j++)
          src.push_back({$urandom, $urandom, $urandom, $urandom});
      end
      start_cmd(vt[i].wr, vt[i].addr, vt[i].len);
      wait_done(3000);
      chk("nbursts", b_len.size(), vt[i].nb);
      if (b_len.size() > 0) begin
        chk("bl_first", b_len[0], vt[i].bl0);
        chk("addr_first", b_addr[0], vt[i].addr & 32'hFFFF_FFF0);
        chk("bl_last", b_len[b_len.size()-1], vt[i].bll);
        chk("addr_last", b_addr[b_addr.size()-1], vt[i].al);
      end
      if (vt[i].wr) begin
        chk("beats_written", wbeats, vt[i].len);
        for (int j = 0; j < vt[i].len; j++) begin
          logic [31:0] k;
          k = (vt[i].addr & 32'hFFFF_FFF0) + 32'(j * 16);
          chk("wr_mem", mem.exists(k) ? mem[k] : {128{1'bx}}, src[j]);
        end
      end else begin
        chk("beats_popped", pops, vt[i].len);
        chk("done_after_pop", done_cyc > last_pop, 1);
      end
      chk("no_overflow", max_occ <= 128, 1);
      if (i == 0) chk("rd_wait_cycles", wait_cyc, 3);
    end

    // Zero-length command: done two cycles after accept, bus untouched.
    wmode = 0;
    gap_en = 0;
    src.delete();
    src_idx = 0;
    start_cmd(0, 32'h6000_0000, 0);
    wait_done(20);
    chk("len0_latency", done_cyc - acc_cyc, 2);
    chk("len0_no_bus", rw_cyc, 0);

    // 100-beat read with a stalled consumer: both bursts fit in the FIFO.
    rd_ready_en = 0;
    start_cmd(0, 32'h4000_0000, 100);
    repeat (200) step();
    chk("stall100_bursts", b_len.size(), 2);
    chk("stall100_occ", occ, 100);
    chk("stall100_nodone", done_cnt, 0);
    rd_ready_en = 1;
    wait_done(500);
    chk("stall100_pops", pops, 100);
    chk("stall100_addr2", b_addr[b_addr.size()-1], 32'h4000_0400);
    chk("stall100_ovf", max_occ <= 128, 1);

    // 200-beat read with a stalled consumer: third burst must be withheld.
    rd_ready_en = 0;
    start_cmd(0, 32'h5000_0000, 200);
    repeat (200) step();
    chk("stall200_bursts", b_len.size(), 2);
    chk("stall200_occ", occ, 128);
    chk("stall200_nodone", done_cnt, 0);
    rd_ready_en = 1;
    wait_done(800);
    chk("stall200_nbursts", b_len.size(), 4);
    chk("stall200_lastbl", b_len[b_len.size()-1], 8);
    chk("stall200_lastaddr", b_addr[b_addr.size()-1], 32'h5000_0C00);
    chk("stall200_pops", pops, 200);
    chk("stall200_ovf", max_occ <= 128, 1);

    // Reset in the middle of a write burst, then a clean read.
    for (int j = 0; j < 10; j++) src.push_back({4{$urandom}});
    src_idx = 0;
    start_cmd(1, 32'h7000_0000, 10);
    repeat (5) step();
    chk("midwr_active", wbeats > 0, 1);
    rst_n = 1'b0;
    src.delete();
    src_idx = 0;
    repeat (3) step();
    chk("midwr_rst_ready", cmd_ready, 0);
    chk("midwr_rst_write", write, 0);
    w_left   = 0;
    rp_beats = 0;
    occ      = 0;
    cmd_pend = 0;
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_write", write, 0);
    chk("post_rst_ready", cmd_ready, 1);
    start_cmd(0, 32'h0000_0500, 4);
    wait_done(200);
    chk("post_rst_pops", pops, 4);
    chk("post_rst_bursts", b_len.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
